mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between the IF stage (instruction fetch) and the MEM stage (load/store).
//  Grants one requester at a time and holds the memory bus for WAIT_CYC+1 cycles.
//  Returns a single-cycle done per access and drives per-port stalls into the pipeline hazard logic.
//  Sits between the pipeline stages and the memory array.
// PARAMETERS
//  ADDR_W    9   byte address width, same as the memory address bus
//  DATA_W    32  data width
//  WAIT_CYC  1   extra wait states per access (0..15); an access occupies WAIT_CYC+1 cycles
//  FAIR_MAX  4   consecutive data grants allowed while fetch waits (used only with ARB_FAIR_EN)
// PORTS
//  clk      in   1       clock, rising edge
//  reset    in   1       synchronous, active-high
//  if_req   in   1       fetch request; held with if_addr until if_done
//  if_addr  in   ADDR_W  fetch address (word read)
//  if_rdata out  DATA_W  fetch data
//  if_done  out  1       fetch access completes this cycle
//  if_stall out  1       if_req & ~if_done
//  d_req    in   1       data request; held with operands until d_done
//  d_rw     in   1       0 = read, 1 = write
//  d_size   in   2       00 byte, 01 half, 10 word
//  d_se     in   1       sign-extend loads
//  d_addr   in   ADDR_W  data address
//  d_wdata  in   DATA_W  store data
//  d_rdata  out  DATA_W  load data
//  d_done   out  1       data access completes this cycle
//  d_stall  out  1       d_req & ~d_done
//  m_en     out  1       memory enable
//  m_rw     out  1       memory direction
//  m_we     out  1       write strobe; asserted only in the last access cycle
//  m_size   out  2       memory access size
//  m_se     out  1       memory sign-extend
//  m_addr   out  ADDR_W  memory address
//  m_wdata  out  DATA_W  memory write data
//  m_rdata  in   DATA_W  memory read data (combinational from m_addr)
// BEHAVIOUR
//  Reset values
//  - FSM = IDLE, wait counter = 0, owner = none.
//  - All m_* outputs = 0; if_done = d_done = 0.
//  - Read holding registers = 0, so if_rdata = d_rdata = 0.
//  - Fairness counter = 0.
//  FSM: IDLE, ACCESS
//  - IDLE, any req: pick owner, latch addr/rw/size/se/wdata, cnt <= WAIT_CYC, go to ACCESS.
//  - Owner choice: data beats fetch; fetch-only requests get fetch.
//  - IDLE, no req: stay in IDLE; m_* = 0.
//  - ACCESS: m_en = 1; m_* driven from the latched registers, stable for the whole access.
//  - ACCESS, cnt > 0: cnt decrements.
//  - ACCESS, cnt == 0 (last cycle): m_we = latched rw.
//  - Last cycle: owner's done = 1 (combinational); owner's rdata = m_rdata.
//  - Last cycle: holding register captures m_rdata for reads; FSM returns to IDLE.
//  - Fetch accesses: rw = 0, size = 10, se = 0.
//  Latency and rdata rules
//  - From req (cycle 0) to done is WAIT_CYC+1 cycles; there is no grant in the done cycle.
//  - A new request is arbitrated in the cycle after done.
//  - Outside its done cycle, rdata shows the last captured value; writes leave rdata unchanged.
//  Boundary conditions
//  - req dropped mid-access: the access still completes, m_we fires, done pulses; done is ignorable.
//  - req operands change mid-access: ignored; the latched values are used.
//  - reset mid-access: abort at the edge; m_we is never issued for that write; all outputs go to reset values.
//  - Simultaneous req: only one grant per IDLE cycle; the loser keeps stall asserted.
//  - WAIT_CYC = 0: done in cycle 1; the counter is always 0.
// CONFIGURATION
//  ARB_FAIR_EN defined:
//  - fair_cnt counts data grants issued while if_req is high.
//  - At fair_cnt == FAIR_MAX with if_req high, the next grant goes to fetch.
//  - fair_cnt clears on any fetch grant or when if_req is low at a grant.
//  ARB_FAIR_EN undefined: strict data priority; no counter; fetch can starve while d_req stays high.
// STRUCTURE
//  Package mem_arb_pkg holds:
//  - state enum (IDLE, ACCESS)
//  - owner encoding (OWN_NONE, OWN_IF, OWN_D)
//  - size constants (SZ_BYTE 00, SZ_HALF 01, SZ_WORD 10)
//  One sub-module, mem_arb_wait_cnt:
//  - loadable down-counter; inputs load/value; output last = (cnt == 0 & active).
//  The fairness counter lives in the top level under `ifdef.
// TESTING
//  1. WAIT_CYC=1, if_req with if_addr=0x004 at cycle 0 -> m_en=1 in cycles 1-2; if_done=1 only in cycle 2.
//     Same test -> if_rdata = m_rdata; if_stall=1 in cycles 0-1.
//  2. if_req and d_req both rise at cycle 0, WAIT_CYC=1 -> d_done in cycle 2; fetch granted in cycle 3; if_done in cycle 5.
//  3. Word write 0xDEADBEEF to 0x010, then a word read of 0x010 -> m_we high exactly once (write's last cycle).
//     Same test -> d_rdata = 0xDEADBEEF at the read's done.
//  4. reset asserted in cycle 1 of a WAIT_CYC=2 write -> m_we never high; next cycle all outputs 0, FSM IDLE.
//  5. ARB_FAIR_EN, FAIR_MAX=2, d_req and if_req held high -> grant order D,D,I,D,D,I.
//     Without the macro -> if_done never asserts while d_req is held.
//  6. WAIT_CYC=0, d_req dropped in cycle 1 of a read -> d_done still pulses in cycle 1; next IDLE sees no request.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter.
// Contents:
//   arb_state_e - arbiter FSM states (IDLE, ACCESS)
//   owner_e     - which pipeline port owns the current access
//   SZ_*        - memory access size encodings
//   WCNT_W      - width of the wait-state counter (WAIT_CYC range 0..15)
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WCNT_W = 4;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Wait-state down-counter for the memory port arbiter.
// Loaded with the wait-state count when an access is granted, then counts
// down once per cycle while the access is active. 'last' flags the final
// cycle of the access (count exhausted while active).
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high
//   load   in  load 'value' into the counter (grant cycle)
//   active in  an access is in progress
//   value  in  count to load
//   last   out final cycle of the running access
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              active,
  input  logic [WCNT_W-1:0] value,
  output logic              last
);

  logic [WCNT_W-1:0] cnt_r;

  // Counter register: load on grant, decrement while active, rest at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {WCNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= value;
    end else if (active && (cnt_r != {WCNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(WCNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = active & (cnt_r == {WCNT_W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch (IF) and the
// load/store (MEM) pipeline stages. One requester is granted at a time and
// owns the memory bus for WAIT_CYC+1 cycles; the owner gets a one-cycle done
// pulse in the last access cycle and the loser sees its stall held.
// Optional feature: define ARB_FAIR_EN to let fetch in after FAIR_MAX
// consecutive data grants issued while fetch was waiting. Without it data
// has strict priority.
// Ports:
//   clk, reset                     clock / synchronous active-high reset
//   if_req, if_addr                fetch request (word read)
//   if_rdata, if_done, if_stall    fetch response and stall
//   d_req, d_rw, d_size, d_se,
//   d_addr, d_wdata                data request (load/store)
//   d_rdata, d_done, d_stall       data response and stall
//   m_en, m_rw, m_we, m_size,
//   m_se, m_addr, m_wdata          memory bus (zero while idle)
//   m_rdata                        memory read data (combinational)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1,
  parameter int FAIR_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic              d_se,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              m_en,
  output logic              m_rw,
  output logic              m_we,
  output logic [1:0]        m_size,
  output logic              m_se,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  owner_e            owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic              rw_r;
  logic [1:0]        size_r;
  logic              se_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] if_hold_r;
  logic [DATA_W-1:0] d_hold_r;
  logic              grant_d_s;
  logic              grant_if_s;
  logic              fetch_turn_s;
  logic              active_s;
  logic              last_s;

  assign active_s = (state_r == ACCESS);

`ifdef ARB_FAIR_EN
  localparam int FAIR_W = (FAIR_MAX < 1) ? 1 : $clog2(FAIR_MAX + 1);

  logic [FAIR_W-1:0] fair_cnt_r;

  // Fetch takes the next grant once data has won FAIR_MAX times in a row.
  assign fetch_turn_s = if_req & (fair_cnt_r == FAIR_W'(FAIR_MAX));

  // Fairness counter: counts data grants made while fetch was waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      fair_cnt_r <= {FAIR_W{1'b0}};
    end else if (grant_if_s) begin
      fair_cnt_r <= {FAIR_W{1'b0}};
    end else if (grant_d_s) begin
      if (if_req) begin
        fair_cnt_r <= fair_cnt_r + {{(FAIR_W-1){1'b0}}, 1'b1};
      end else begin
        fair_cnt_r <= {FAIR_W{1'b0}};
      end
    end else begin
      fair_cnt_r <= fair_cnt_r;
    end
  end
`else
  assign fetch_turn_s = 1'b0;
`endif

  // Arbitration: only in IDLE, one grant per cycle, data first unless it is fetch's turn.
  always_comb begin
    grant_d_s  = 1'b0;
    grant_if_s = 1'b0;
    if (state_r == IDLE) begin
      if (d_req && !fetch_turn_s) begin
        grant_d_s = 1'b1;
      end else if (if_req) begin
        grant_if_s = 1'b1;
      end else begin
        grant_d_s  = 1'b0;
        grant_if_s = 1'b0;
      end
    end else begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
    end
  end

  mem_arb_wait_cnt u_wait_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (grant_d_s | grant_if_s),
    .active (active_s),
    .value  (WCNT_W'(WAIT_CYC)),
    .last   (last_s)
  );

  // Next-state logic: an access always runs to its last cycle unless reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s || grant_if_s) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Access latches: captured at grant so requester operand changes mid-access are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r <= OWN_NONE;
      addr_r  <= {ADDR_W{1'b0}};
      rw_r    <= 1'b0;
      size_r  <= SZ_BYTE;
      se_r    <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
    end else if (grant_d_s) begin
      owner_r <= OWN_D;
      addr_r  <= d_addr;
      rw_r    <= d_rw;
      size_r  <= d_size;
      se_r    <= d_se;
      wdata_r <= d_wdata;
    end else if (grant_if_s) begin
      owner_r <= OWN_IF;
      addr_r  <= if_addr;
      rw_r    <= 1'b0;
      size_r  <= SZ_WORD;
      se_r    <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
    end else if (last_s) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= owner_r;
    end
  end

  // Read holding registers: keep the last value read by each port; stores leave d_hold_r alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_hold_r <= {DATA_W{1'b0}};
      d_hold_r  <= {DATA_W{1'b0}};
    end else begin
      if (if_done) begin
        if_hold_r <= m_rdata;
      end else begin
        if_hold_r <= if_hold_r;
      end
      if (d_done && !rw_r) begin
        d_hold_r <= m_rdata;
      end else begin
        d_hold_r <= d_hold_r;
      end
    end
  end

  // Memory bus and handshake outputs; the bus is quiet (all zero) outside an access.
  always_comb begin
    m_en    = 1'b0;
    m_rw    = 1'b0;
    m_we    = 1'b0;
    m_size  = SZ_BYTE;
    m_se    = 1'b0;
    m_addr  = {ADDR_W{1'b0}};
    m_wdata = {DATA_W{1'b0}};
    if_done = 1'b0;
    d_done  = 1'b0;
    if (active_s) begin
      m_en    = 1'b1;
      m_rw    = rw_r;
      m_we    = last_s & rw_r;
      m_size  = size_r;
      m_se    = se_r;
      m_addr  = addr_r;
      m_wdata = wdata_r;
      if_done = last_s & (owner_r == OWN_IF);
      d_done  = last_s & (owner_r == OWN_D);
    end else begin
      m_en = 1'b0;
    end
    if (if_done) begin
      if_rdata = m_rdata;
    end else begin
      if_rdata = if_hold_r;
    end
    if (d_done) begin
      d_rdata = m_rdata;
    end else begin
      d_rdata = d_hold_r;
    end
  end

  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (WAIT_CYC=1, FAIR_MAX=2).
// A byte-array memory sits on the m_* bus; a separate reference memory is
// updated per completed transaction and predicts all read data.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 32;
  localparam int WAIT_CYC = 1;
  localparam int FAIR_MAX = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;
  logic              d_req;
  logic              d_rw;
  logic [1:0]        d_size;
  logic              d_se;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_stall;
  logic              m_en;
  logic              m_rw;
  logic              m_we;
  logic [1:0]        m_size;
  logic              m_se;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_if_hold;
  logic [31:0] exp_d_hold;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC), .FAIR_MAX(FAIR_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_se(d_se),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_stall(d_stall),
    .m_en(m_en), .m_rw(m_rw), .m_we(m_we), .m_size(m_size), .m_se(m_se),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Memory array on the bus: combinational read, write on m_we at the clock edge.
  logic [7:0]  mem     [0:511];
  logic [7:0]  ref_mem [0:511];
  logic [31:0] mem_raw;

  always_comb begin
    mem_raw = {mem[m_addr + 9'd3], mem[m_addr + 9'd2], mem[m_addr + 9'd1], mem[m_addr]};
    case (m_size)
      2'b00:   m_rdata = {{24{m_se & mem_raw[7]}}, mem_raw[7:0]};
      2'b01:   m_rdata = {{16{m_se & mem_raw[15]}}, mem_raw[15:0]};
      default: m_rdata = mem_raw;
    endcase
  end

  always @(posedge clk) begin
    if (m_we) begin
      mem[m_addr] <= m_wdata[7:0];
      if (m_size != 2'b00) mem[m_addr + 9'd1] <= m_wdata[15:8];
      if (m_size == 2'b10) begin
        mem[m_addr + 9'd2] <= m_wdata[23:16];
        mem[m_addr + 9'd3] <= m_wdata[31:24];
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'((i * 37 + 11) % 256);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  // Reference read: little-endian byte sum, optional sign extension to 32 bits.
  function automatic logic [31:0] ref_read(input logic [8:0] addr, input logic [1:0] sz,
                                           input bit se);
    longint unsigned v;
    int n;
    n = size_bytes(sz);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v + (longint'(ref_mem[(int'(addr) + i) % 512]) << (8 * i));
    if (se && n < 4 && v >= (64'd1 << (8 * n - 1)))
      v = v + (64'd1 << 32) - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_write(input logic [8:0] addr, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < size_bytes(sz); i++)
      ref_mem[(int'(addr) + i) % 512] = 8'(wd >> (8 * i));
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_rw = 1'b0;
    d_size = 2'b00; d_se = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  // One complete access on a port; checks latency, bus stability, write strobe and read data.
  task automatic do_access(input bit is_d, input bit rw, input logic [1:0] sz, input bit se,
                           input logic [8:0] addr, input logic [31:0] wd);
    int lat, we_seen;
    bit got, bus_bad;
    logic [31:0] exp, obs;
    if (is_d) exp = ref_read(addr, sz, se);
    else exp = ref_read(addr, 2'b10, 1'b0);
    if (is_d) begin
      d_req = 1'b1; d_rw = rw; d_size = sz; d_se = se; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = 0; we_seen = 0; got = 1'b0; bus_bad = 1'b0; obs = '0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (m_we) we_seen++;
      if (!m_en || m_addr !== addr) bus_bad = 1'b1;
      if (is_d ? d_done : if_done) begin
        got = 1'b1; lat = c; obs = is_d ? d_rdata : if_rdata;
      end else if (!(is_d ? d_stall : if_stall)) bus_bad = 1'b1;
    end
    if_req = 1'b0; d_req = 1'b0;
    tests_run++;
    if (!got || lat != WAIT_CYC + 1) begin
      tests_failed++;
      $display("FAIL access_latency: got %0d cycles (done seen %0d), need %0d", lat, got, WAIT_CYC + 1);
    end
    tests_run++;
    if (bus_bad) begin
      tests_failed++;
      $display("FAIL access_bus: m_en/m_addr/stall wrong during access to 0x%0h", addr);
    end
    tests_run++;
    if (we_seen != ((is_d && rw) ? 1 : 0)) begin
      tests_failed++;
      $display("FAIL access_we: m_we seen %0d times, need %0d", we_seen, (is_d && rw) ? 1 : 0);
    end
    if (is_d && rw) begin
      ref_write(addr, sz, wd);
    end else begin
      if (is_d) exp_d_hold = exp; else exp_if_hold = exp;
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL access_rdata: addr 0x%0h got 0x%08h need 0x%08h", addr, obs, exp);
      end
    end
    @(negedge clk);
    tests_run++;
    if (d_rdata !== exp_d_hold || if_rdata !== exp_if_hold || m_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL rdata_hold: d 0x%08h/0x%08h if 0x%08h/0x%08h m_en %0b",
               d_rdata, exp_d_hold, if_rdata, exp_if_hold, m_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({m_en, m_rw, m_we, m_size, m_se, m_addr, m_wdata, if_done, d_done, if_rdata, d_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: outputs not all zero under reset (m_addr 0x%0h d_rdata 0x%0h)", m_addr, d_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({m_en, m_we, if_done, d_done, if_stall, d_stall} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: control outputs %b after reset, need 000000",
               {m_en, m_we, if_done, d_done, if_stall, d_stall});
    end
    exp_if_hold = '0; exp_d_hold = '0;
  endtask

  task automatic test_fetch_single();
    tests_run++;
    if_req = 1'b1;
    #1;
    if (if_stall !== 1'b1 || m_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_cycle0: if_stall %0b m_en %0b, need 1 0", if_stall, m_en);
    end
    if_req = 1'b0;
    do_access(1'b0, 1'b0, 2'b10, 1'b0, 9'h004, 32'h0);
  endtask

  task automatic test_write_read();
    do_access(1'b1, 1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    tests_run++;
    if (exp_d_hold !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL write_read: readback 0x%08h need 0xdeadbeef", exp_d_hold);
    end
  endtask

  task automatic test_simultaneous();
    int dcyc, icyc;
    bit addr_ok, stall_ok;
    dcyc = 0; icyc = 0; addr_ok = 1'b0; stall_ok = 1'b0;
    if_req = 1'b1; if_addr = 9'h040;
    d_req = 1'b1; d_rw = 1'b0; d_size = 2'b10; d_se = 1'b0; d_addr = 9'h080;
    for (int c = 1; c <= 16 && icyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) addr_ok = (m_addr === 9'h080);
      if (d_done && dcyc == 0) begin
        dcyc = c; stall_ok = (if_stall === 1'b1); d_req = 1'b0;
        exp_d_hold = d_rdata;
      end
      if (if_done) begin
        icyc = c; if_req = 1'b0; exp_if_hold = if_rdata;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tests_run++;
    if (dcyc != WAIT_CYC + 1 || icyc != 2 * WAIT_CYC + 3) begin
      tests_failed++;
      $display("FAIL simul_order: d_done at %0d i_done at %0d, need %0d %0d",
               dcyc, icyc, WAIT_CYC + 1, 2 * WAIT_CYC + 3);
    end
    tests_run++;
    if (!addr_ok || !stall_ok) begin
      tests_failed++;
      $display("FAIL simul_grant: data-first addr %0b, fetch stalled %0b, need 1 1", addr_ok, stall_ok);
    end
    tests_run++;
    if (exp_d_hold !== ref_read(9'h080, 2'b10, 1'b0) || exp_if_hold !== ref_read(9'h040, 2'b10, 1'b0)) begin
      tests_failed++;
      $display("FAIL simul_rdata: d 0x%08h if 0x%08h", exp_d_hold, exp_if_hold);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int we_seen;
    we_seen = 0;
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_se = 1'b0; d_addr = 9'h020; d_wdata = 32'h12345678;
    @(negedge clk);
    if (m_we) we_seen++;
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    if (m_we) we_seen++;
    tests_run++;
    if ({m_en, m_rw, m_we, m_size, m_se, m_addr, m_wdata, if_done, d_done, if_rdata, d_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: m_en %0b m_addr 0x%0h m_wdata 0x%0h d_rdata 0x%0h",
               m_en, m_addr, m_wdata, d_rdata);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m_we) we_seen++;
    end
    tests_run++;
    if (we_seen != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_we: m_we seen %0d times, need 0", we_seen);
    end
    exp_if_hold = '0; exp_d_hold = '0;
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 9'h020, 32'h0);
  endtask

  task automatic test_fairness();
    bit seq [6];
    bit exp_seq [6];
    int n;
`ifdef ARB_FAIR_EN
    exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    n = 0;
    if_req = 1'b1; if_addr = 9'h100;
    d_req = 1'b1; d_rw = 1'b0; d_size = 2'b10; d_se = 1'b0; d_addr = 9'h104;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (d_done) begin seq[n] = 1'b1; n++; exp_d_hold = d_rdata; end
      else if (if_done) begin seq[n] = 1'b0; n++; exp_if_hold = if_rdata; end
    end
    if_req = 1'b0; d_req = 1'b0;
    tests_run++;
    if (n != 6) begin
      tests_failed++;
      $display("FAIL fair_count: %0d grants completed, need 6", n);
    end
    for (int k = 0; k < n; k++) begin
      tests_run++;
      if (seq[k] !== exp_seq[k]) begin
        tests_failed++;
        $display("FAIL fair_order: grant %0d went to %s, need %s", k,
                 seq[k] ? "D" : "I", exp_seq[k] ? "D" : "I");
      end
    end
    @(negedge clk);
  endtask

  task automatic test_drop_mid();
    int dcyc;
    logic [31:0] obs, exp;
    exp = ref_read(9'h0C2, 2'b01, 1'b1);
    dcyc = 0; obs = '0;
    d_req = 1'b1; d_rw = 1'b0; d_size = 2'b01; d_se = 1'b1; d_addr = 9'h0C2;
    for (int c = 1; c <= 10 && dcyc == 0; c++) begin
      @(negedge clk);
      if (d_done) begin dcyc = c; obs = d_rdata; end
      if (c == 1) begin d_req = 1'b0; d_addr = 9'h1F0; d_size = 2'b00; end
    end
    d_req = 1'b0;
    tests_run++;
    if (dcyc != WAIT_CYC + 1 || obs !== exp) begin
      tests_failed++;
      $display("FAIL drop_mid: done at %0d data 0x%08h, need %0d 0x%08h", dcyc, obs, WAIT_CYC + 1, exp);
    end
    exp_d_hold = exp;
    @(negedge clk);
    tests_run++;
    if (m_en !== 1'b0 || d_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_idle: m_en %0b d_done %0b after dropped request, need 0 0", m_en, d_done);
    end
  endtask

  task automatic test_random();
    logic [1:0] sz;
    logic [8:0] addr;
    bit is_d, rw, se;
    for (int k = 0; k < 40; k++) begin
      is_d = ($urandom_range(0, 3) != 0);
      rw   = is_d && ($urandom_range(0, 1) == 1);
      sz   = is_d ? 2'($urandom_range(0, 2)) : 2'b10;
      se   = is_d && ($urandom_range(0, 1) == 1);
      addr = 9'($urandom_range(0, 511));
      if (sz == 2'b10) addr = addr & 9'h1FC;
      else if (sz == 2'b01) addr = addr & 9'h1FE;
      do_access(is_d, rw, sz, se, addr, $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'((i * 37 + 11) % 256);
    idle_inputs();
    reset = 1'b1;
    exp_if_hold = '0; exp_d_hold = '0;
    @(negedge clk);
    test_reset();
    test_fetch_single();
    test_write_read();
    test_simultaneous();
    test_reset_mid_write();
    test_fairness();
    test_drop_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
